// File: rtl/mips_cpu_hilo_pkg.sv
// Shared types and constants for the HI/LO result unit.
package mips_cpu_hilo_pkg;

    localparam int unsigned DIV_ITER = 32;
    localparam int unsigned CNT_W    = 5;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } hilo_op_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIV_RUN = 2'd1,
        ST_DIV_FIX = 2'd2
    } hilo_state_t;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mips_cpu_hilo_divcore.sv
// Unsigned restoring divider: one quotient bit per step, DIV_ITER steps per divide.
module mips_cpu_hilo_divcore
    import mips_cpu_hilo_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        step_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o,
    output logic        last_o
);

    logic [31:0]      quot_q, quot_d;
    logic [31:0]      rem_q,  rem_d;
    logic [31:0]      dvsr_q, dvsr_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [32:0]      rem_shift_s;
    logic [32:0]      diff_s;

    // Trial subtraction; the quotient register doubles as the dividend shifter.
    always_comb begin
        rem_shift_s = {rem_q, quot_q[31]};
        diff_s      = rem_shift_s - {1'b0, dvsr_q};
        quot_d      = quot_q;
        rem_d       = rem_q;
        dvsr_d      = dvsr_q;
        cnt_d       = cnt_q;
        if (start_i) begin
            quot_d = dividend_i;
            rem_d  = 32'd0;
            dvsr_d = divisor_i;
            cnt_d  = {CNT_W{1'b0}};
        end else if (step_i) begin
            quot_d = {quot_q[30:0], ~diff_s[32]};
            rem_d  = diff_s[32] ? rem_shift_s[31:0] : diff_s[31:0];
            cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot_q <= 32'd0;
            rem_q  <= 32'd0;
            dvsr_q <= 32'd0;
            cnt_q  <= {CNT_W{1'b0}};
        end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dvsr_q <= dvsr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign quot_o = quot_q;
    assign rem_o  = rem_q;
    assign last_o = (cnt_q == CNT_W'(DIV_ITER - 1));

endmodule

// File: rtl/mips_cpu_hilo.sv
// HI/LO result unit: single-cycle multiply, MTHI/MTLO, and sequential signed/unsigned divide.
module mips_cpu_hilo
    import mips_cpu_hilo_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        done_o,
    output logic        div_by_zero_o
);

    hilo_state_t        state_q, state_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
    logic               busy_q, busy_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;

    hilo_op_t           op_s;
    logic               accept_s;
    logic               signed_div_s;
    logic [31:0]        mag_a_s, mag_b_s;
    logic signed [63:0] prod_signed_s;
    logic [63:0]        prod_unsigned_s;
    logic               start_s, step_s;
    logic [31:0]        quot_s, rem_s;
    logic               last_s;

    assign op_s            = hilo_op_t'(op_i);
    assign accept_s        = op_valid_i && (state_q == ST_IDLE) && !flush_i;
    assign signed_div_s    = (op_s == OP_DIV);
    assign mag_a_s         = signed_div_s ? abs32(a_i) : a_i;
    assign mag_b_s         = signed_div_s ? abs32(b_i) : b_i;
    assign prod_signed_s   = $signed(a_i) * $signed(b_i);
    assign prod_unsigned_s = {32'd0, a_i} * {32'd0, b_i};

    mips_cpu_hilo_divcore u_divcore (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_s),
        .step_i     (step_s),
        .dividend_i (mag_a_s),
        .divisor_i  (mag_b_s),
        .quot_o     (quot_s),
        .rem_o      (rem_s),
        .last_o     (last_s)
    );

    // Next-state, HI/LO write and divider control.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        start_s = 1'b0;
        step_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (op_s)
                        OP_MULT: begin
                            {hi_d, lo_d} = prod_signed_s;
                            done_d       = 1'b1;
                        end
                        OP_MULTU: begin
                            {hi_d, lo_d} = prod_unsigned_s;
                            done_d       = 1'b1;
                        end
                        OP_MTHI: begin
                            hi_d   = a_i;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = a_i;
                            done_d = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (b_i == 32'd0) begin
                                hi_d   = a_i;
                                lo_d   = 32'hFFFF_FFFF;
                                done_d = 1'b1;
                                dbz_d  = 1'b1;
                            end else begin
                                start_s = 1'b1;
                                q_neg_d = signed_div_s & (a_i[31] ^ b_i[31]);
                                r_neg_d = signed_div_s & a_i[31];
                                state_d = ST_DIV_RUN;
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DIV_RUN: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    step_s = 1'b1;
                    if (last_s) begin
                        state_d = ST_DIV_FIX;
                    end else begin
                        state_d = ST_DIV_RUN;
                    end
                end
            end
            ST_DIV_FIX: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    lo_d    = neg_if(quot_s, q_neg_q);
                    hi_d    = neg_if(rem_s, r_neg_q);
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Architectural and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
        end
    end

    assign busy_o        = busy_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_mips_cpu_hilo.sv
// Directed bench for mips_cpu_hilo with hand-computed expected values.
module tb_mips_cpu_hilo;
    import mips_cpu_hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;
    int cyc;

    mips_cpu_hilo dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op_valid_i    (op_valid),
        .op_i          (op),
        .a_i           (a),
        .b_i           (b),
        .flush_i       (flush),
        .busy_o        (busy),
        .hi_o          (hi),
        .lo_o          (lo),
        .done_o        (done),
        .div_by_zero_o (dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single edge; returns at the negedge of the following cycle.
    task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        op_valid = 1'b1;
        op = o;
        a = va;
        b = vb;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    // Counts busy cycles from the current negedge, bounded at 100.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            op_valid = 1'b0;
        end
    endtask

    initial begin
        #12;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dbz", {31'd0, dbz}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        chk("mult_done", {31'd0, done}, 32'd1);
        chk("mult_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("mult_done_pulse", {31'd0, done}, 32'd0);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);
        issue(OP_MTLO, 32'h1234_5678, 32'd0);
        chk("mtlo_lo", lo, 32'h1234_5678);
        chk("mtlo_hi", hi, 32'hFFFF_FFFE);
        chk("mtlo_done", {31'd0, done}, 32'd1);

        // flush in IDLE blocks a same-cycle request
        @(negedge clk);
        flush = 1'b1;
        op_valid = 1'b1;
        op = OP_MTHI;
        a = 32'hDEAD_0000;
        @(negedge clk);
        flush = 1'b0;
        op_valid = 1'b0;
        chk("idle_flush_hi", hi, 32'hFFFF_FFFE);
        chk("idle_flush_done", {31'd0, done}, 32'd0);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_busy_start", {31'd0, busy}, 32'd1);
        op_valid = 1'b1;
        op = OP_MTHI;
        a = 32'h0000_0BAD;
        wait_idle(cyc);
        chk("div_busy_cycles", cyc, 32'd33);
        chk("div_done", {31'd0, done}, 32'd1);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("div_dbz", {31'd0, dbz}, 32'd0);

        issue(OP_DIVU, 32'd100, 32'd0);
        chk("dbz_hi", hi, 32'd100);
        chk("dbz_lo", lo, 32'hFFFF_FFFF);
        chk("dbz_done", {31'd0, done}, 32'd1);
        chk("dbz_flag", {31'd0, dbz}, 32'd1);
        chk("dbz_busy", {31'd0, busy}, 32'd0);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(cyc);
        chk("ovf_cycles", cyc, 32'd33);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'd0);

        issue(OP_DIVU, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        chk("flush_busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_hi", hi, 32'd0);
        chk("flush_lo", lo, 32'h8000_0000);
        chk("flush_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("flush_done_late", {31'd0, done}, 32'd0);

        issue(OP_DIVU, 32'd1000, 32'd7);
        wait_idle(cyc);
        chk("divu_cycles", cyc, 32'd33);
        chk("divu_lo", lo, 32'd142);
        chk("divu_hi", hi, 32'd6);
        chk("divu_done", {31'd0, done}, 32'd1);

        issue(OP_DIV, 32'd50, 32'd3);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_stays_idle", {31'd0, busy}, 32'd0);
        issue(OP_MULT, 32'd5, 32'hFFFF_FFFE);
        chk("post_rst_hi", hi, 32'hFFFF_FFFF);
        chk("post_rst_lo", lo, 32'hFFFF_FFF6);
        chk("post_rst_done", {31'd0, done}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_cpu_hilo.md
Name: mips_cpu_hilo

Overview:
HI/LO result unit for the MIPS core. It receives MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the ALU/decode stage and owns the architectural HI and LO registers. It computes the product in a single cycle and the quotient/remainder with a 32-iteration sequential divider. It is the write/issue side that the MFHI/MFLO readers and the pipeline stall logic depend on.

Parameters:
- DIV_ITER, 32, number of divide iterations; fixed by the 32-bit operand width.

Ports:
- clk, input, 1, core clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- op_valid, input, 1, request strobe; sampled only when busy=0.
- op, input, 3, opcode: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are ignored.
- a, input, 32, rs operand (dividend / multiplicand / MTHI-MTLO data).
- b, input, 32, rt operand (divisor / multiplier).
- flush, input, 1, synchronous abort of an in-flight divide (exception path).
- busy, output, 1, high while a divide is in progress; the pipeline stalls MFHI/MFLO/new HI-LO ops on it.
- hi, output, 32, architectural HI register.
- lo, output, 32, architectural LO register.
- done, output, 1, one-cycle pulse in the cycle after HI and/or LO are written.
- div_by_zero, output, 1, valid with done; high when the completed op was DIV/DIVU with b=0.

Behaviour:
- Reset (rst_n=0, async): hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE, iteration counter=0. Reset mid-divide discards the operation entirely.
- States: IDLE, DIV_RUN, DIV_FIX.
- Acceptance: a request is taken at edge N if op_valid=1, busy=0, and flush=0. op_valid while busy=1 is dropped; the producer must stall on busy.
- MULTU: {hi,lo} <= a*b, unsigned 64-bit, at edge N. done=1 in cycle N+1. busy stays 0.
- MULT: {hi,lo} <= signed 64-bit product at edge N. done=1 in cycle N+1.
- MTHI / MTLO: hi <= a or lo <= a at edge N; the other register is unchanged. done=1 in cycle N+1.
- DIV/DIVU with b≠0: at edge N, latch |a|, |b| (raw values for DIVU), quotient sign = a[31]^b[31] and remainder sign = a[31] (both 0 for DIVU). Then go to DIV_RUN with count=0.
- DIV_RUN: one restoring step per edge (shift the remainder left 1, subtract the divisor, keep the result if non-negative, shift the quotient bit in). At the edge with count=31, go to DIV_FIX.
- DIV_FIX: apply the signs, then lo <= quotient and hi <= remainder at edge N+33, returning to IDLE. busy=1 during cycles N+1..N+33. done=1 in cycle N+34.
- Signed results: the quotient truncates toward zero and the remainder takes the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- Divide by zero (b=0): no iterations. At edge N, hi <= a, lo <= 0xFFFFFFFF (both signed and unsigned). done=1 and div_by_zero=1 in cycle N+1.
- flush=1 while busy: return to IDLE at the next edge; hi and lo are unchanged; no done pulse. flush in IDLE has no effect and blocks a same-cycle op_valid.
- hi and lo change only at the write edges described above; they are stable at all other times.

Decomposition:
- Package mips_cpu_hilo_pkg holds the op encoding enum (hilo_op_t), the state enum (hilo_state_t), and DIV_ITER.
- Sub-module mips_cpu_hilo_divcore: an unsigned iterative restoring divider (start, magnitudes in, quotient/remainder out, last-iteration flag). The parent handles sign conversion, the zero-divisor case, and flush.

Test Plan:
- MULT a=0xFFFFFFFE, b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA, done in the next cycle, busy never asserted.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then MTLO a=0x12345678 -> lo=0x12345678, hi unchanged.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy for exactly 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF, done on the 34th cycle; an op_valid during busy is ignored.
- DIVU a=100, b=0 -> hi=100, lo=0xFFFFFFFF, done and div_by_zero in the next cycle. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=1000, b=7 with flush on the 10th busy cycle -> busy drops the next cycle, hi/lo keep their prior values, no done pulse. A new DIVU then gives lo=142, hi=6.
- rst_n asserted asynchronously mid-DIV -> busy, hi, lo, and done all go to 0 immediately. After release, the unit accepts a MULT normally.
